// File: rtl/psx_link_pkg.sv
// Shared types and constants for the serial packet router.
// Holds the parser states and the flags-to-length decode.
package psx_link_pkg;

    typedef enum logic [2:0] {
        ST_HEADER,
        ST_FLAGS,
        ST_PAYLOAD,
        ST_CHECK,
        ST_COMMIT,
        ST_DISCARD
    } state_t;

    localparam logic [3:0] SYNC_NIBBLE_DEF = 4'h5;

    localparam int LEN_W = 5;
    localparam logic [LEN_W-1:0] LEN_NONE  = 5'd0;
    localparam logic [LEN_W-1:0] LEN_SHORT = 5'd2;
    localparam logic [LEN_W-1:0] LEN_MID   = 5'd6;
    localparam logic [LEN_W-1:0] LEN_LONG  = 5'd18;

    // Highest set flag bit wins.
    function automatic logic [LEN_W-1:0] flags_to_len(
        input logic [7:0] flags
    );
        logic [LEN_W-1:0] len;
        if (flags[2])
            len = LEN_LONG;
        else if (flags[1])
            len = LEN_MID;
        else if (flags[0])
            len = LEN_SHORT;
        else
            len = LEN_NONE;
        return len;
    endfunction

endpackage

// File: rtl/pkt_buffer.sv
// Payload store: one synchronous write port, one combinational
// read port so the commit path can fetch a byte one cycle ahead.
module pkt_buffer #(
    parameter int DEPTH = 18,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (we && int'(waddr) < DEPTH) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = (int'(raddr) < DEPTH) ? mem[raddr] : '0;

endmodule

// File: rtl/serial_packet_router.sv
// Parses framed serial packets, checks the sum and replays the
// payload as a register-write burst to one controller slot.
module serial_packet_router
    import psx_link_pkg::*;
#(
    parameter int         NUM_PORTS   = 4,
    parameter int         ADDR_W      = 5,
    parameter int         MAX_PAYLOAD = 18,
    parameter logic [3:0] SYNC_NIBBLE = SYNC_NIBBLE_DEF,
    parameter bit         CHECKSUM_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [7:0]           rx_data,
    input  logic                 rx_strobe,
    input  logic                 rx_idle,
    output logic [ADDR_W-1:0]    write_addr,
    output logic [7:0]           write_data,
    output logic [NUM_PORTS-1:0] write_en,
    output logic                 packet_done,
    output logic                 packet_error,
    output logic                 busy,
    output logic [7:0]           err_count
);

    localparam int IDX_W = $clog2(MAX_PAYLOAD + 1);

    state_t state_q, state_d;
    logic [3:0]       port_q, port_d;
    logic [IDX_W-1:0] len_q, len_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       sum_q, sum_d;
    logic             ovr_q, ovr_d;

    logic             buf_we;
    logic [IDX_W-1:0] buf_waddr;
    logic [IDX_W-1:0] buf_raddr;
    logic [7:0]       buf_rdata;

    logic [NUM_PORTS-1:0] port_mask;
    logic [NUM_PORTS-1:0] wen_d;
    logic [ADDR_W-1:0]    addr_d;
    logic [7:0]           data_d;
    logic                 done_d;
    logic                 err_d;
    logic                 enter_commit;
    logic [LEN_W-1:0]     flen;

    pkt_buffer #(
        .DEPTH (MAX_PAYLOAD),
        .AW    (IDX_W)
    ) u_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (buf_we),
        .waddr   (buf_waddr),
        .wdata   (rx_data),
        .raddr   (buf_raddr),
        .rdata   (buf_rdata)
    );

    // Out-of-range ports decode to an empty mask: silent drop.
    always_comb begin
        port_mask = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            port_mask[i] = (int'(port_q) == i);
    end

    assign buf_raddr = (state_q == ST_COMMIT) ? idx_q : '0;

    always_comb begin
        state_d      = state_q;
        port_d       = port_q;
        len_d        = len_q;
        idx_d        = idx_q;
        sum_d        = sum_q;
        ovr_d        = ovr_q;
        buf_we       = 1'b0;
        buf_waddr    = idx_q;
        wen_d        = '0;
        addr_d       = '0;
        data_d       = '0;
        done_d       = 1'b0;
        err_d        = 1'b0;
        enter_commit = 1'b0;
        flen         = flags_to_len(rx_data);

        unique case (state_q)
            ST_HEADER: begin
                if (rx_strobe) begin
                    if (rx_data[7:4] != SYNC_NIBBLE) begin
                        err_d   = 1'b1;
                        state_d = ST_DISCARD;
                    end else begin
                        port_d  = rx_data[3:0];
                        sum_d   = rx_data;
                        state_d = ST_FLAGS;
                    end
                end
            end
            ST_FLAGS: begin
                if (rx_idle) begin
                    state_d = ST_HEADER;
                end else if (rx_strobe) begin
                    sum_d = 8'(sum_q + rx_data);
                    idx_d = '0;
                    if (int'(flen) > MAX_PAYLOAD) begin
                        err_d   = 1'b1;
                        state_d = ST_DISCARD;
                    end else begin
                        len_d = IDX_W'(flen);
                        if (flen != '0)
                            state_d = ST_PAYLOAD;
                        else if (CHECKSUM_EN)
                            state_d = ST_CHECK;
                        else
                            enter_commit = 1'b1;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (rx_idle) begin
                    state_d = ST_HEADER;
                end else if (rx_strobe) begin
                    buf_we = 1'b1;
                    sum_d  = 8'(sum_q + rx_data);
                    idx_d  = idx_q + 1'b1;
                    if (idx_q == len_q - 1'b1) begin
                        if (CHECKSUM_EN)
                            state_d = ST_CHECK;
                        else
                            enter_commit = 1'b1;
                    end
                end
            end
            ST_CHECK: begin
                if (rx_idle) begin
                    state_d = ST_HEADER;
                end else if (rx_strobe) begin
                    if (8'(sum_q + rx_data) == 8'h00) begin
                        enter_commit = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_HEADER;
                    end
                end
            end
            ST_COMMIT: begin
                if (rx_strobe)
                    err_d = 1'b1;
                if (idx_q < len_q) begin
                    wen_d  = port_mask;
                    addr_d = ADDR_W'(idx_q);
                    data_d = buf_rdata;
                    idx_d  = idx_q + 1'b1;
                    if (rx_strobe)
                        ovr_d = 1'b1;
                end else begin
                    done_d  = 1'b1;
                    ovr_d   = 1'b0;
                    state_d = (ovr_q || rx_strobe) ? ST_DISCARD
                                                   : ST_HEADER;
                end
            end
            ST_DISCARD: begin
                if (rx_idle)
                    state_d = ST_HEADER;
            end
            default: state_d = ST_HEADER;
        endcase

        // First write goes out on the entry edge to meet N+1 latency.
        if (enter_commit) begin
            state_d = ST_COMMIT;
            ovr_d   = 1'b0;
            if (len_d != '0) begin
                wen_d  = port_mask;
                addr_d = '0;
                data_d = buf_rdata;
                idx_d  = IDX_W'(1);
            end else begin
                idx_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_HEADER;
            port_q       <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            sum_q        <= '0;
            ovr_q        <= 1'b0;
            write_en     <= '0;
            write_addr   <= '0;
            write_data   <= '0;
            packet_done  <= 1'b0;
            packet_error <= 1'b0;
            busy         <= 1'b0;
            err_count    <= '0;
        end else begin
            state_q      <= state_d;
            port_q       <= port_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            sum_q        <= sum_d;
            ovr_q        <= ovr_d;
            write_en     <= wen_d;
            write_addr   <= addr_d;
            write_data   <= data_d;
            packet_done  <= done_d;
            packet_error <= err_d;
            busy         <= (state_d != ST_HEADER);
            if (err_d && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_serial_packet_router.sv
// Scoreboard bench for serial_packet_router: expected writes are
// queued when a packet is sent and popped as write_en fires.
module tb_serial_packet_router;

    localparam int NP = 4;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          rx_strobe = 1'b0;
    logic          rx_idle = 1'b0;
    logic [AW-1:0] write_addr;
    logic [7:0]    write_data;
    logic [NP-1:0] write_en;
    logic          packet_done;
    logic          packet_error;
    logic          busy;
    logic [7:0]    err_count;

    serial_packet_router #(
        .NUM_PORTS   (NP),
        .ADDR_W      (AW),
        .MAX_PAYLOAD (18),
        .SYNC_NIBBLE (4'h5),
        .CHECKSUM_EN (1'b1)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_data      (rx_data),
        .rx_strobe    (rx_strobe),
        .rx_idle      (rx_idle),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .write_en     (write_en),
        .packet_done  (packet_done),
        .packet_error (packet_error),
        .busy         (busy),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NP-1:0] en;
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    wr_t exp_q[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int strobe_cyc = 0;
    int first_wr = -1;
    int last_wr = -1;
    int done_cyc = -1;
    int done_seen = 0;
    int err_seen = 0;
    int exp_done = 0;
    int exp_err = 0;
    int err_model = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        wr_t e;
        if (reset_n) begin
            if (write_en != '0) begin
                if (first_wr < 0)
                    first_wr = cyc;
                last_wr = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_wr", 64'(write_en), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr", 64'({write_en, write_addr, write_data}),
                        64'(e));
                end
            end
            if (packet_done) begin
                done_seen++;
                done_cyc = cyc;
            end
            if (packet_error)
                err_seen++;
        end
    end

    function automatic int len_of(input logic [7:0] f);
        if (f[2]) return 18;
        if (f[1]) return 6;
        if (f[0]) return 2;
        return 0;
    endfunction

    task automatic expect_err();
        exp_err++;
        if (err_model < 255)
            err_model++;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data = b;
        rx_strobe = 1'b1;
        strobe_cyc = cyc;
        @(posedge clk);
        #1;
        rx_strobe = 1'b0;
    endtask

    task automatic pulse_idle();
        @(posedge clk);
        #1 rx_idle = 1'b1;
        @(posedge clk);
        #1 rx_idle = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_timeout"}, 64'(n >= 200), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_left"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_done"}, 64'(done_seen), 64'(exp_done));
        chk({tag, "_errs"}, 64'(err_seen), 64'(exp_err));
        chk({tag, "_errcnt"}, 64'(err_count), 64'(err_model));
    endtask

    // Sends a well-formed packet; bad_ck corrupts the checksum byte.
    task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] flags,
                            input logic [7:0] pl[$], input bit bad_ck);
        logic [7:0] s;
        wr_t w;
        s = hdr + flags;
        foreach (pl[i]) s = s + pl[i];
        s = 8'h00 - s;
        if (bad_ck) begin
            s = s + 8'h01;
            expect_err();
        end else begin
            exp_done++;
            for (int i = 0; i < pl.size(); i++) begin
                if (int'(hdr[3:0]) < NP) begin
                    w.en = NP'(1) << hdr[3:0];
                    w.addr = AW'(i);
                    w.data = pl[i];
                    exp_q.push_back(w);
                end
            end
        end
        first_wr = -1;
        last_wr = -1;
        done_cyc = -1;
        send_byte(hdr);
        send_byte(flags);
        foreach (pl[i]) send_byte(pl[i]);
        send_byte(s);
    endtask

    task automatic make_pl(input int n, input logic [7:0] base,
                           output logic [7:0] q[$]);
        q.delete();
        for (int i = 0; i < n; i++)
            q.push_back(8'(base + 8'(i * 7)));
    endtask

    initial begin
        logic [7:0] pl[$];
        int n;

        #1;
        chk("rst_wen", 64'(write_en), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(packet_done), 64'd0);
        chk("rst_err", 64'(packet_error), 64'd0);
        chk("rst_errcnt", 64'(err_count), 64'd0);
        chk("rst_addr", 64'(write_addr), 64'd0);
        #22 reset_n = 1'b1;

        pl = '{8'h11, 8'h22};
        send_pkt(8'h50, 8'h01, pl, 1'b0);
        drain("p0");
        check_state("p0");
        chk("p0_first_lat", 64'(first_wr), 64'(strobe_cyc + 1));
        chk("p0_last_lat", 64'(last_wr), 64'(strobe_cyc + 2));
        chk("p0_done_lat", 64'(done_cyc), 64'(last_wr + 1));

        send_pkt(8'h50, 8'h01, pl, 1'b1);
        drain("badck");
        check_state("badck");
        chk("badck_busy", 64'(busy), 64'd0);

        make_pl(18, 8'h30, pl);
        send_pkt(8'h53, 8'h04, pl, 1'b0);
        drain("p3");
        check_state("p3");
        chk("p3_first_lat", 64'(first_wr), 64'(strobe_cyc + 1));
        chk("p3_burst", 64'(last_wr - first_wr + 1), 64'd18);

        send_byte(8'hA0);
        expect_err();
        send_byte(8'h51);
        send_byte(8'h00);
        send_byte(8'hAF);
        pulse_idle();
        pl.delete();
        send_pkt(8'h51, 8'h00, pl, 1'b0);
        drain("sync");
        check_state("sync");
        chk("sync_nowr", 64'(first_wr), 64'hFFFF_FFFF_FFFF_FFFF);

        send_byte(8'h52);
        send_byte(8'h02);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        pulse_idle();
        repeat (2) @(negedge clk);
        check_state("abort");
        make_pl(6, 8'h90, pl);
        send_pkt(8'h52, 8'h02, pl, 1'b0);
        drain("after_abort");
        check_state("after_abort");

        pl = '{8'hDE, 8'hAD};
        send_pkt(8'h5F, 8'h01, pl, 1'b0);
        drain("drop");
        check_state("drop");

        make_pl(18, 8'h05, pl);
        send_pkt(8'h52, 8'h04, pl, 1'b0);
        repeat (3) @(negedge clk);
        send_byte(8'h00);
        expect_err();
        repeat (30) @(negedge clk);
        chk("ovr_discard_busy", 64'(busy), 64'd1);
        pulse_idle();
        drain("ovr");
        check_state("ovr");

        for (int i = 0; i < 300; i++) begin
            send_byte(8'h0C);
            expect_err();
            pulse_idle();
        end
        drain("sat");
        check_state("sat");

        make_pl(18, 8'h40, pl);
        send_pkt(8'h51, 8'h04, pl, 1'b0);
        n = 0;
        while (write_en == '0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("mid_wait_timeout", 64'(n >= 100), 64'd0);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_wen", 64'(write_en), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_errcnt", 64'(err_count), 64'd0);
        chk("mid_rst_done", 64'(packet_done), 64'd0);
        exp_q.delete();
        err_model = 0;
        exp_done = done_seen;
        #20 reset_n = 1'b1;

        pl = '{8'h11, 8'h22};
        send_pkt(8'h50, 8'h01, pl, 1'b0);
        drain("post_rst");
        check_state("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
